// File: rtl/sram_pkg.sv
// Shared state encoding, default timing/width constants and the wait-counter
// sizing helper for the asynchronous SRAM controller.
package sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_t;

  localparam int DEF_ADDR_W     = 20;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_RD_WAIT    = 2;
  localparam int DEF_WR_WAIT    = 2;
  localparam int DEF_BLINK_BITS = 22;

  // One counter serves both read and write waits, so it must hold the larger load.
  function automatic int cnt_width(input int rd_wait, input int wr_wait);
    int max_wait;
    int width;
    max_wait = (rd_wait > wr_wait) ? rd_wait : wr_wait;
    width    = $clog2(max_wait + 1);
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/alive_blinker.sv
// Free-running heartbeat counter; its MSB drives the alive LED straight from a flop.
module alive_blinker
  import sram_pkg::*;
#(
  parameter int BLINK_BITS = DEF_BLINK_BITS
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_led
);

  logic [BLINK_BITS-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_reset) count <= '0;
    else         count <= count + 1'b1;
  end

  assign o_led = count[BLINK_BITS-1];

endmodule

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: one read or write at a time, with
// configurable access waits and every SRAM strobe registered.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_WAIT    = DEF_RD_WAIT,
  parameter int WR_WAIT    = DEF_WR_WAIT,
  parameter int BLINK_BITS = DEF_BLINK_BITS
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ready,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_wack,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_led
);

  localparam int CNT_W = cnt_width(RD_WAIT, WR_WAIT);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             accept;
  logic             rd_done;
  logic             wr_done;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    rd_done = 1'b0;
    wr_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_req) begin
          accept  = 1'b1;
          state_n = i_we ? ST_WR_SETUP : ST_RD;
          cnt_n   = RD_LOAD;
        end
      end
      ST_RD: begin
        if (cnt == '0) begin
          rd_done = 1'b1;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_WR_SETUP: begin
        state_n = ST_WR_PULSE;
        cnt_n   = WR_LOAD;
      end
      ST_WR_PULSE: begin
        if (cnt == '0) state_n = ST_WR_HOLD;
        else           cnt_n   = cnt - 1'b1;
      end
      ST_WR_HOLD: begin
        wr_done = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so pins change only on clock edges.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      o_sram_ce_n  <= 1'b1;
      o_sram_oe_n  <= 1'b1;
      o_sram_we_n  <= 1'b1;
      o_sram_dq_oe <= 1'b0;
      o_rvalid     <= 1'b0;
      o_wack       <= 1'b0;
      o_rdata      <= '0;
      o_sram_addr  <= '0;
      o_sram_dq    <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      o_sram_ce_n  <= (state_n == ST_IDLE);
      o_sram_oe_n  <= (state_n != ST_RD);
      o_sram_we_n  <= (state_n != ST_WR_PULSE);
      o_sram_dq_oe <= (state_n == ST_WR_SETUP) || (state_n == ST_WR_PULSE) ||
                      (state_n == ST_WR_HOLD);
      o_rvalid     <= rd_done;
      o_wack       <= wr_done;
      if (rd_done) o_rdata <= i_sram_dq;
      if (accept) begin
        o_sram_addr <= i_addr;
        o_sram_dq   <= i_wdata;
      end
    end
  end

  assign o_ready = (state == ST_IDLE);

  alive_blinker #(
    .BLINK_BITS(BLINK_BITS)
  ) u_blinker (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .o_led  (o_led)
  );

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: directed vector table, randomized traffic
// against a memory reference model, and multi-cycle corner sequences.
module tb_sram_ctrl;

  localparam int AW  = 20;
  localparam int DW  = 8;
  localparam int RDW = 2;
  localparam int WRW = 2;
  localparam int BB  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, req, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready, rvalid, wack, led;
  logic [DW-1:0] rdata;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq, sram_q;
  logic          dq_oe, ce_n, oe_n, we_n;

  logic          req_f, we_f;
  logic [AW-1:0] addr_f;
  logic [DW-1:0] wdata_f;
  logic          ready_f, rvalid_f, wack_f, led_f;
  logic [DW-1:0] rdata_f;
  logic [AW-1:0] sram_addr_f;
  logic [DW-1:0] sram_dq_f, sram_q_f;
  logic          dq_oe_f, ce_n_f, oe_n_f, we_n_f;

  int compared   = 0;
  int mismatched = 0;

  sram_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RDW), .WR_WAIT(WRW), .BLINK_BITS(BB)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .o_ready(ready), .o_rvalid(rvalid), .o_rdata(rdata),
    .o_wack(wack), .o_sram_addr(sram_addr), .o_sram_dq(sram_dq),
    .o_sram_dq_oe(dq_oe), .i_sram_dq(sram_q), .o_sram_ce_n(ce_n),
    .o_sram_oe_n(oe_n), .o_sram_we_n(we_n), .o_led(led)
  );

  sram_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .RD_WAIT(0), .WR_WAIT(0), .BLINK_BITS(BB)
  ) dut_fast (
    .i_clk(clk), .i_reset(reset), .i_req(req_f), .i_we(we_f), .i_addr(addr_f),
    .i_wdata(wdata_f), .o_ready(ready_f), .o_rvalid(rvalid_f), .o_rdata(rdata_f),
    .o_wack(wack_f), .o_sram_addr(sram_addr_f), .o_sram_dq(sram_dq_f),
    .o_sram_dq_oe(dq_oe_f), .i_sram_dq(sram_q_f), .o_sram_ce_n(ce_n_f),
    .o_sram_oe_n(oe_n_f), .o_sram_we_n(we_n_f), .o_led(led_f)
  );

  // SRAM device models, pin-activity counters and the strobe-overlap monitor.
  logic [DW-1:0] mem   [int];
  logic [DW-1:0] mem_f [int];
  logic [DW-1:0] ref_mem [int];
  int we_low = 0, dq_high = 0, oe_low = 0, rvalid_cnt = 0, wack_cnt = 0, viol = 0;

  always @(negedge clk) begin
    if (!ce_n && !we_n) mem[int'(sram_addr)] = sram_dq;
    if (!ce_n && !oe_n && mem.exists(int'(sram_addr))) sram_q = mem[int'(sram_addr)];
    else sram_q = '0;
    if (!ce_n_f && !we_n_f) mem_f[int'(sram_addr_f)] = sram_dq_f;
    if (!ce_n_f && !oe_n_f && mem_f.exists(int'(sram_addr_f))) sram_q_f = mem_f[int'(sram_addr_f)];
    else sram_q_f = '0;
    if (!we_n)  we_low++;
    if (dq_oe)  dq_high++;
    if (!oe_n)  oe_low++;
    if (rvalid) rvalid_cnt++;
    if (wack)   wack_cnt++;
    if ((!oe_n && !we_n) || (dq_oe && !oe_n) || (!oe_n_f && !we_n_f) || (dq_oe_f && !oe_n_f)) begin
      viol++;
      $display("[TB] FAIL strobe_overlap: oe_n=%b we_n=%b dq_oe=%b fast oe_n=%b we_n=%b dq_oe=%b, required no overlap",
               oe_n, we_n, dq_oe, oe_n_f, we_n_f, dq_oe_f);
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int guard = 0;
    while (!ready && guard < 64) begin
      tick();
      guard++;
    end
    check_output({name, " ready_timeout"}, 32'(guard < 64), 32'd1);
  endtask

  // One complete transaction on the main instance, checked against timing and data rules.
  task automatic apply_stimulus(input string name, input logic t_we, input logic [AW-1:0] t_addr,
                                input logic [DW-1:0] t_wdata, input logic [DW-1:0] t_exp);
    int lat, s_we, s_dq, s_oe;
    wait_ready(name);
    s_we = we_low; s_dq = dq_high; s_oe = oe_low;
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
    tick();
    req = 1'b0; we = 1'b0; addr = AW'($urandom); wdata = DW'($urandom);
    lat = 0;
    while (!(t_we ? wack : rvalid) && lat < 64) begin
      tick();
      lat++;
    end
    if (t_we) begin
      check_output({name, " wack_latency"}, lat, WRW + 3);
      check_output({name, " we_n_low_cycles"}, we_low - s_we, WRW + 1);
      check_output({name, " dq_oe_cycles"}, dq_high - s_dq, WRW + 3);
      check_output({name, " sram_holds"}, mem.exists(int'(t_addr)) ? 32'(mem[int'(t_addr)]) : 32'hDEAD,
                   32'(t_wdata));
      ref_mem[int'(t_addr)] = t_wdata;
    end else begin
      check_output({name, " rvalid_latency"}, lat, RDW + 1);
      check_output({name, " rdata"}, rdata, t_exp);
      check_output({name, " oe_n_low_cycles"}, oe_low - s_oe, RDW + 1);
      check_output({name, " dq_oe_cycles"}, dq_high - s_dq, 0);
    end
    check_output({name, " ready_at_done"}, ready, 1'b1);
  endtask

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int acc, s_w, s_r, n;
    logic          t_we;
    logic [AW-1:0] ta;
    logic [DW-1:0] td, te;

    tbl[0] = '{1'b1, 20'hFFFFF, 8'h3C, 8'h00};
    tbl[1] = '{1'b0, 20'hFFFFF, 8'h00, 8'h3C};
    tbl[2] = '{1'b1, 20'h12345, 8'hA5, 8'h00};
    tbl[3] = '{1'b0, 20'h12345, 8'h00, 8'hA5};
    tbl[4] = '{1'b0, 20'h00001, 8'h00, 8'h00};
    tbl[5] = '{1'b1, 20'h00000, 8'hC3, 8'h00};
    tbl[6] = '{1'b0, 20'h00000, 8'h00, 8'hC3};
    tbl[7] = '{1'b0, 20'hFFFFF, 8'h00, 8'h3C};

    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req_f = 1'b0; we_f = 1'b0; addr_f = '0; wdata_f = '0;
    repeat (3) tick();

    check_output("reset ready", ready, 1'b1);
    check_output("reset ce_n", ce_n, 1'b1);
    check_output("reset oe_n", oe_n, 1'b1);
    check_output("reset we_n", we_n, 1'b1);
    check_output("reset dq_oe", dq_oe, 1'b0);
    check_output("reset rvalid", rvalid, 1'b0);
    check_output("reset wack", wack, 1'b0);
    check_output("reset rdata", rdata, 0);
    check_output("reset sram_addr", sram_addr, 0);
    check_output("reset sram_dq", sram_dq, 0);
    check_output("reset led", led, 1'b0);

    // Blinker: counter is zero after reset, so the MSB of a 4-bit count flips every 8 cycles.
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      check_output($sformatf("blink k=%0d", k), led, 32'((k / (1 << (BB - 1))) % 2));
      tick();
    end

    for (int i = 0; i < 8; i++)
      apply_stimulus($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp);

    for (int i = 0; i < 40; i++) begin
      t_we = 1'($urandom_range(0, 1));
      ta   = 20'hF0000 | AW'($urandom_range(0, 7));
      td   = DW'($urandom);
      te   = ref_mem.exists(int'(ta)) ? ref_mem[int'(ta)] : '0;
      apply_stimulus($sformatf("rand%0d", i), t_we, ta, td, te);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Request held high through a write: only one further request is taken, once ready returns.
    ta = 20'h0ABCD;
    wait_ready("hold_req");
    s_w = wack_cnt; s_r = rvalid_cnt; acc = 0;
    for (int i = 0; i < 8; i++) begin
      req = 1'b1; we = (i == 0); addr = ta; wdata = 8'h96;
      if (ready) acc++;
      tick();
    end
    req = 1'b0; we = 1'b0;
    n = 0;
    while (!rvalid && n < 32) begin
      tick();
      n++;
    end
    check_output("hold_req accepts", acc, 2);
    check_output("hold_req rdata", rdata, 8'h96);
    repeat (4) tick();
    check_output("hold_req wack_count", wack_cnt - s_w, 1);
    check_output("hold_req rvalid_count", rvalid_cnt - s_r, 1);
    ref_mem[int'(ta)] = 8'h96;

    // Reset during the write pulse aborts the write.
    wait_ready("abort_wr");
    s_w = wack_cnt;
    req = 1'b1; we = 1'b1; addr = 20'h0F00F; wdata = 8'h77;
    tick();
    req = 1'b0;
    tick();
    check_output("abort_wr in_pulse we_n", we_n, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("abort_wr we_n", we_n, 1'b1);
    check_output("abort_wr dq_oe", dq_oe, 1'b0);
    check_output("abort_wr ce_n", ce_n, 1'b1);
    check_output("abort_wr ready", ready, 1'b1);
    repeat (8) tick();
    check_output("abort_wr no_wack", wack_cnt - s_w, 0);

    // Reset during a read suppresses its completion pulse.
    s_r = rvalid_cnt;
    req = 1'b1; we = 1'b0; addr = 20'h12345;
    tick();
    req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("abort_rd oe_n", oe_n, 1'b1);
    repeat (6) tick();
    check_output("abort_rd no_rvalid", rvalid_cnt - s_r, 0);
    check_output("abort_rd ready", ready, 1'b1);

    // Reset wins over a request presented on the same edge.
    reset = 1'b1; req = 1'b1; we = 1'b0; addr = 20'h00001;
    tick();
    reset = 1'b0; req = 1'b0;
    check_output("reset_vs_req ready", ready, 1'b1);
    check_output("reset_vs_req oe_n", oe_n, 1'b1);
    check_output("reset_vs_req ce_n", ce_n, 1'b1);

    // Zero-wait instance: write, then read the same address in the o_wack cycle.
    n = 0;
    while (!ready_f && n < 16) begin
      tick();
      n++;
    end
    req_f = 1'b1; we_f = 1'b1; addr_f = 20'h00055; wdata_f = 8'h55;
    tick();
    req_f = 1'b0; we_f = 1'b0; wdata_f = 8'h00;
    n = 0;
    while (!wack_f && n < 32) begin
      tick();
      n++;
    end
    check_output("fast wack_latency", n, 3);
    check_output("fast ready_on_wack", ready_f, 1'b1);
    req_f = 1'b1; we_f = 1'b0; addr_f = 20'h00055;
    tick();
    req_f = 1'b0;
    n = 1;
    while (!rvalid_f && n < 32) begin
      tick();
      n++;
    end
    check_output("fast rvalid_after_wack", n, 2);
    check_output("fast rdata", rdata_f, 8'h55);

    tick();
    check_output("strobe_overlap count", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, SRAM address width (1M locations).
REQ-002 SHALL have parameter DATA_W, default 8, SRAM data width.
REQ-003 SHALL have parameter RD_WAIT, default 2, extra read-access cycles (0 legal).
REQ-004 SHALL have parameter WR_WAIT, default 2, extra WE_n-low cycles (0 legal).
REQ-005 SHALL have parameter BLINK_BITS, default 22, alive-blinker counter width.
REQ-006 SHALL have port i_clk  in  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port i_reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port i_req  in  1  transaction request.
REQ-009 SHALL have port i_we  in  1  1=write, 0=read; sampled with i_req.
REQ-010 SHALL have port i_addr  in  ADDR_W  transaction address.
REQ-011 SHALL have port i_wdata  in  DATA_W  write data.
REQ-012 SHALL have port o_ready  out  1  controller idle, request acceptable.
REQ-013 SHALL have port o_rvalid  out  1  one-cycle pulse, o_rdata valid.
REQ-014 SHALL have port o_rdata  out  DATA_W  last read data, held until next read.
REQ-015 SHALL have port o_wack  out  1  one-cycle pulse, write complete.
REQ-016 SHALL have ports o_sram_addr out ADDR_W, o_sram_dq out DATA_W, o_sram_dq_oe out 1, i_sram_dq in DATA_W, o_sram_ce_n / o_sram_oe_n / o_sram_we_n out 1 each.
REQ-017 SHALL have port o_led  out  1  alive-blink (counter MSB).

Function
REQ-018 Accept: request taken on edge where i_req && o_ready; i_we, i_addr, i_wdata captured into registers on that edge.
REQ-019 o_ready SHALL be high only in IDLE; i_req while not ready ignored, not queued.
REQ-020 States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD; single down-counter loaded from RD_WAIT or WR_WAIT.
REQ-021 RD: ce_n=0, oe_n=0, we_n=1, dq_oe=0, address driven; lasts RD_WAIT+1 cycles; i_sram_dq sampled into o_rdata on final RD edge.
REQ-022 Read latency: accept edge N -> o_rvalid high in cycle after edge N+RD_WAIT+1, concurrent with o_ready=1 (back-to-back accept allowed).
REQ-023 WR_SETUP 1 cycle: ce_n=0, we_n=1, oe_n=1, dq_oe=1, address and data driven.
REQ-024 WR_PULSE WR_WAIT+1 cycles: we_n=0, all else as WR_SETUP.
REQ-025 WR_HOLD 1 cycle: we_n=1, address/data/dq_oe held; then IDLE with o_wack pulse in first IDLE cycle.
REQ-026 Write occupancy: WR_WAIT+3 cycles from accept to o_ready.
REQ-027 oe_n and we_n SHALL never be low simultaneously; dq_oe SHALL never be 1 while oe_n=0.
REQ-028 All SRAM pins and o_led SHALL be driven directly from flops (glitch-free).
REQ-029 IDLE: ce_n=oe_n=we_n=1, dq_oe=0, o_sram_addr holds last value.
REQ-030 Blinker: free-running BLINK_BITS counter, wraps at all-ones to 0, unaffected by transactions.

Reset
REQ-031 On i_reset edge: state=IDLE, o_ready=1 next cycle, ce_n=oe_n=we_n=1, dq_oe=0, o_rvalid=o_wack=0, o_rdata=0, o_sram_addr=0, o_sram_dq=0, blinker=0.
REQ-032 Reset mid-transaction SHALL abort it: no o_rvalid/o_wack, we_n high on the following cycle.
REQ-033 i_reset SHALL dominate a coincident i_req.

Structure
REQ-034 Package sram_pkg SHALL hold state enumeration and default timing/width constants.
REQ-035 Blinker SHALL be sub-module alive_blinker (param BLINK_BITS; ports i_clk, i_reset, o_led).
REQ-036 Counter width SHALL be $clog2(max(RD_WAIT,WR_WAIT)+1), minimum 1.

Verification
REQ-037 Read, RD_WAIT=2, addr 0x12345, model returns 0xA5 -> oe_n low 3 cycles, o_rvalid 4th cycle after accept, o_rdata=0xA5.
REQ-038 Write 0x3C to 0xFFFFF, WR_WAIT=2 -> we_n low exactly 3 cycles, dq_oe high 5 cycles, o_wack after 5 cycles, model holds 0x3C.
REQ-039 Write 0x55 then immediate read same address (RD_WAIT=0) -> read accepted on o_wack cycle, o_rvalid 2 cycles later, data 0x55.
REQ-040 i_req held high during write -> ignored until o_ready; exactly one extra transaction accepted.
REQ-041 i_reset asserted during WR_PULSE -> we_n=1, dq_oe=0 next cycle, no o_wack, o_ready=1.
REQ-042 BLINK_BITS=4 -> o_led toggles every 8 cycles; assertion monitor for REQ-027 throughout.
